// File: rtl/dsm_pkg.sv
// Shared types, constants and fixed-point helpers for the delta-sigma modulator.
package dsm_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRun     = 2'd1,
    StRecover = 2'd2
  } dsm_state_e;

  localparam logic [15:0] LfsrSeed = 16'hACE1;
  // Right-shifting Fibonacci form of x^16 + x^14 + x^13 + x^11: feedback from bits 0, 2, 3, 5.
  localparam logic [15:0] LfsrTapMask = 16'h002D;

  // Feedback magnitude: full scale sits GUARD bits below the integrator MSB.
  function automatic longint fs_value(int unsigned width, int unsigned guard);
    return longint'(1) << (width - 1 - guard);
  endfunction

  function automatic longint sat_max(int unsigned width);
    return (longint'(1) << (width - 1)) - 1;
  endfunction

  function automatic longint sat_min(int unsigned width);
    return -(longint'(1) << (width - 1));
  endfunction

endpackage

// File: rtl/dsm_modulator_gen_if.sv
// Sample-side bus of the modulator: control/sample inputs and pin/status outputs.
interface dsm_modulator_gen_if #(
  parameter int unsigned WIDTH = 20
);
  logic                    en;
  logic                    ce;
  logic signed [WIDTH-1:0] vin;
  logic                    pwm;
  logic                    overload;
  logic [15:0]             overload_cnt;
  logic                    busy;

  modport master (output en, ce, vin, input pwm, overload, overload_cnt, busy);
  modport slave  (input en, ce, vin, output pwm, overload, overload_cnt, busy);
endinterface

// File: rtl/dsm_sat_integrator.sv
// Signed saturating accumulator: acc <= clamp(acc + inc - fb) on ce, with clear priority.
module dsm_sat_integrator
  import dsm_pkg::*;
#(
  parameter int unsigned WIDTH = 20
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    ce,
  input  logic signed [WIDTH-1:0] inc,
  input  logic signed [WIDTH-1:0] fb,
  output logic signed [WIDTH-1:0] acc,
  output logic                    clamp
);

  localparam logic signed [WIDTH+1:0] SatMax = (WIDTH+2)'(sat_max(WIDTH));
  localparam logic signed [WIDTH+1:0] SatMin = (WIDTH+2)'(sat_min(WIDTH));

  logic signed [WIDTH-1:0] acc_q;
  logic signed [WIDTH-1:0] acc_d;
  logic signed [WIDTH+1:0] sum;

  // Two guard bits keep the three-term sum exact before clamping.
  always_comb begin
    sum   = (WIDTH+2)'(acc_q) + (WIDTH+2)'(inc) - (WIDTH+2)'(fb);
    acc_d = sum[WIDTH-1:0];
    clamp = 1'b0;
    if (sum > SatMax) begin
      acc_d = SatMax[WIDTH-1:0];
      clamp = 1'b1;
    end else if (sum < SatMin) begin
      acc_d = SatMin[WIDTH-1:0];
      clamp = 1'b1;
    end
  end

  // Accumulator state; clear wins over ce so en-drop needs no strobe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
    end else if (clear) begin
      acc_q <= '0;
    end else if (ce) begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/dsm_modulator_gen.sv
// Order-1/2 cascade-of-integrators 1-bit delta-sigma modulator with dither and overload recovery.
module dsm_modulator_gen
  import dsm_pkg::*;
#(
  parameter int unsigned WIDTH       = 20,
  parameter int unsigned GUARD       = 4,
  parameter int unsigned ORDER       = 2,
  parameter int unsigned DITHER_BITS = 0,
  parameter int unsigned SAT_LIMIT   = 8,
  parameter int unsigned FLUSH_LEN   = 16
) (
  input logic               clock,
  input logic               reset,
  dsm_modulator_gen_if.slave bus
);

  if (ORDER != 1 && ORDER != 2) begin : g_bad_order
    $error("dsm_modulator_gen: ORDER must be 1 or 2");
  end

  localparam logic signed [WIDTH-1:0] Fs = WIDTH'(fs_value(WIDTH, GUARD));

  dsm_state_e              state_q;
  logic                    pwm_q;
  logic                    overload_q;
  logic                    busy_q;
  logic [15:0]             overload_cnt_q;
  logic [7:0]              sat_cnt_q;
  logic [7:0]              flush_cnt_q;
  logic [15:0]             lfsr_q;
  logic [15:0]             lfsr_next;
  logic signed [WIDTH-1:0] acc [ORDER];
  logic [ORDER-1:0]        clamp;
  logic                    any_clamp;
  logic                    enter_rec;
  logic                    int_clear;
  logic                    q;
  logic signed [WIDTH-1:0] fb;
  logic [WIDTH:0]          dither;
  logic [WIDTH:0]          qsum;

  if (DITHER_BITS == 0) begin : g_no_dither
    assign dither = '0;
  end else begin : g_dither
    assign dither = {{(WIDTH + 1 - DITHER_BITS){lfsr_q[DITHER_BITS-1]}},
                     lfsr_q[DITHER_BITS-1:0]};
  end

  assign lfsr_next = {^(lfsr_q & LfsrTapMask), lfsr_q[15:1]};

  // One extra bit so integrator + dither cannot wrap before the sign test.
  assign qsum = {acc[ORDER-1][WIDTH-1], acc[ORDER-1]} + dither;
  assign q    = ~qsum[WIDTH];
  assign fb   = q ? Fs : -Fs;

  assign any_clamp = |clamp;
  assign enter_rec = (state_q == StRun) && bus.ce && any_clamp &&
                     (sat_cnt_q >= 8'(SAT_LIMIT - 1));
  // Integrators only move in RUN; they are forced to zero on RECOVER entry and while idle.
  assign int_clear = !bus.en || (state_q != StRun) || enter_rec;

  for (genvar g = 0; g < ORDER; g++) begin : g_stage
    logic signed [WIDTH-1:0] inc;
    if (g == 0) begin : g_in
      assign inc = bus.vin;
    end else begin : g_in
      assign inc = acc[g-1];
    end
    dsm_sat_integrator #(
      .WIDTH(WIDTH)
    ) u_int (
      .clock(clock),
      .reset(reset),
      .clear(int_clear),
      .ce   (bus.ce),
      .inc  (inc),
      .fb   (fb),
      .acc  (acc[g]),
      .clamp(clamp[g])
    );
  end

  // Control FSM with registered outputs; en low dominates every other transition.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      pwm_q          <= 1'b0;
      overload_q     <= 1'b0;
      busy_q         <= 1'b0;
      overload_cnt_q <= '0;
      sat_cnt_q      <= '0;
      flush_cnt_q    <= '0;
      lfsr_q         <= LfsrSeed;
    end else if (!bus.en) begin
      state_q     <= StIdle;
      pwm_q       <= 1'b0;
      overload_q  <= 1'b0;
      busy_q      <= 1'b0;
      sat_cnt_q   <= '0;
      flush_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_q <= StRun;
          busy_q  <= 1'b1;
        end
        StRun: begin
          if (bus.ce) begin
            pwm_q  <= q;
            lfsr_q <= lfsr_next;
            if (enter_rec) begin
              state_q     <= StRecover;
              overload_q  <= 1'b1;
              sat_cnt_q   <= 8'(SAT_LIMIT);
              flush_cnt_q <= '0;
              if (overload_cnt_q != 16'hFFFF) overload_cnt_q <= overload_cnt_q + 16'd1;
            end else if (any_clamp) begin
              if (sat_cnt_q < 8'(SAT_LIMIT)) sat_cnt_q <= sat_cnt_q + 8'd1;
            end else begin
              sat_cnt_q <= '0;
            end
          end
        end
        StRecover: begin
          if (bus.ce) begin
            pwm_q  <= ~pwm_q;
            lfsr_q <= lfsr_next;
            if (flush_cnt_q == 8'(FLUSH_LEN - 1)) begin
              state_q     <= StRun;
              overload_q  <= 1'b0;
              sat_cnt_q   <= '0;
              flush_cnt_q <= '0;
            end else begin
              flush_cnt_q <= flush_cnt_q + 8'd1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.pwm          = pwm_q;
  assign bus.overload     = overload_q;
  assign bus.overload_cnt = overload_cnt_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_dsm_modulator_gen.sv
// Bench: three modulator configurations share one stimulus stream and are checked
// every clock against an arithmetic model, plus hand-computed literal expectations.
module tb_dsm_modulator_gen;

  localparam int W = 20;
  localparam longint FS = 32768;
  localparam longint IMAX = 524287;
  localparam longint IMIN = -524288;
  localparam int SAT_LIM = 8;
  localparam int FLUSH = 16;
  localparam int MIdle = 0;
  localparam int MRun = 1;
  localparam int MRec = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b0;
  logic ce = 1'b0;
  logic signed [W-1:0] vin = '0;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  dsm_modulator_gen_if #(.WIDTH(W)) if_a ();
  dsm_modulator_gen_if #(.WIDTH(W)) if_b ();
  dsm_modulator_gen_if #(.WIDTH(W)) if_c ();

  assign if_a.en = en;
  assign if_a.ce = ce;
  assign if_a.vin = vin;
  assign if_b.en = en;
  assign if_b.ce = ce;
  assign if_b.vin = vin;
  assign if_c.en = en;
  assign if_c.ce = ce;
  assign if_c.vin = vin;

  dsm_modulator_gen #(.WIDTH(W), .GUARD(4), .ORDER(1), .DITHER_BITS(0), .SAT_LIMIT(8),
                      .FLUSH_LEN(16)) u_a (.clock(clock), .reset(reset), .bus(if_a));
  dsm_modulator_gen #(.WIDTH(W), .GUARD(4), .ORDER(2), .DITHER_BITS(0), .SAT_LIMIT(8),
                      .FLUSH_LEN(16)) u_b (.clock(clock), .reset(reset), .bus(if_b));
  dsm_modulator_gen #(.WIDTH(W), .GUARD(4), .ORDER(2), .DITHER_BITS(8), .SAT_LIMIT(8),
                      .FLUSH_LEN(16)) u_c (.clock(clock), .reset(reset), .bus(if_c));

  // Model state, one slot per DUT (a, b, c)
  int          m_order [3] = '{1, 2, 2};
  int          m_db    [3] = '{0, 0, 8};
  int          m_mode  [3];
  longint      m_i1    [3];
  longint      m_i2    [3];
  bit          m_pwm   [3];
  int          m_sat   [3];
  int          m_flush [3];
  int          m_ocnt  [3];
  logic [15:0] m_lfsr  [3];

  task automatic check(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_adv(logic [15:0] s);
    logic b;
    b = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {b, s[15:1]};
  endfunction

  function automatic longint dither_of(logic [15:0] s, int db);
    longint r;
    if (db == 0) return 0;
    r = longint'(s) & ((longint'(1) << db) - 1);
    if (r >= (longint'(1) << (db - 1))) r = r - (longint'(1) << db);
    return r;
  endfunction

  function automatic bit out_of_range(longint x);
    return (x > IMAX) || (x < IMIN);
  endfunction

  function automatic longint sat(longint x);
    if (x > IMAX) return IMAX;
    if (x < IMIN) return IMIN;
    return x;
  endfunction

  task automatic model_edge();
    longint v, d, inn, fbv, n1, n2;
    bit q, clamped;
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        m_mode[k] = MIdle; m_i1[k] = 0; m_i2[k] = 0; m_pwm[k] = 0;
        m_sat[k] = 0; m_flush[k] = 0; m_ocnt[k] = 0; m_lfsr[k] = 16'hACE1;
      end else if (!en) begin
        m_mode[k] = MIdle; m_i1[k] = 0; m_i2[k] = 0; m_pwm[k] = 0;
        m_sat[k] = 0; m_flush[k] = 0;
      end else if (m_mode[k] == MIdle) begin
        m_mode[k] = MRun;
      end else if (ce) begin
        if (m_mode[k] == MRun) begin
          v = vin;
          d = dither_of(m_lfsr[k], m_db[k]);
          inn = (m_order[k] == 1) ? m_i1[k] : m_i2[k];
          q = (inn + d >= 0);
          fbv = q ? FS : -FS;
          n1 = m_i1[k] + v - fbv;
          n2 = m_i2[k] + m_i1[k] - fbv;
          clamped = out_of_range(n1) || (m_order[k] == 2 && out_of_range(n2));
          m_i1[k] = sat(n1);
          m_i2[k] = (m_order[k] == 2) ? sat(n2) : 0;
          m_pwm[k] = q;
          m_sat[k] = clamped ? ((m_sat[k] < SAT_LIM) ? m_sat[k] + 1 : m_sat[k]) : 0;
          if (m_sat[k] == SAT_LIM) begin
            m_mode[k] = MRec; m_flush[k] = 0; m_i1[k] = 0; m_i2[k] = 0;
            if (m_ocnt[k] < 65535) m_ocnt[k]++;
          end
        end else begin
          m_pwm[k] = !m_pwm[k];
          if (m_flush[k] == FLUSH - 1) begin
            m_mode[k] = MRun; m_sat[k] = 0; m_flush[k] = 0;
          end else begin
            m_flush[k]++;
          end
        end
        m_lfsr[k] = lfsr_adv(m_lfsr[k]);
      end
    end
  endtask

  task automatic cmp(string tag, int k, logic pwm, logic ov, logic [15:0] cnt, logic busy,
                     logic [15:0] lfsr);
    check({tag, " pwm"}, pwm, m_pwm[k]);
    check({tag, " overload"}, ov, m_mode[k] == MRec);
    check({tag, " overload_cnt"}, cnt, m_ocnt[k]);
    check({tag, " busy"}, busy, m_mode[k] != MIdle);
    check({tag, " lfsr"}, lfsr, m_lfsr[k]);
  endtask

  // Per-cycle compare against the model, sampled 1 time unit after each edge
  initial begin
    forever begin
      @(posedge clock);
      model_edge();
      #1;
      cmp("a", 0, if_a.pwm, if_a.overload, if_a.overload_cnt, if_a.busy, u_a.lfsr_q);
      cmp("b", 1, if_b.pwm, if_b.overload, if_b.overload_cnt, if_b.busy, u_b.lfsr_q);
      cmp("c", 2, if_c.pwm, if_c.overload, if_c.overload_cnt, if_c.busy, u_c.lfsr_q);
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic step_n(int n);
    repeat (n) begin
      @(negedge clock); ce = 1'b1;
      @(negedge clock); ce = 1'b0;
    end
  endtask

  task automatic restart();
    @(negedge clock); en = 1'b0;
    @(negedge clock); en = 1'b1;
    @(negedge clock);
  endtask

  bit          t1_exp [8] = '{1, 0, 1, 0, 1, 0, 1, 0};
  bit          t2_exp [8] = '{1, 0, 1, 1, 1, 0, 1, 1};
  longint      t2_i1  [8] = '{-16384, 32768, 16384, 0, -16384, 32768, 16384, 0};
  logic [15:0] lf_exp [4] = '{16'h5670, 16'hAB38, 16'h559C, 16'h2ACE};

  initial begin
    logic [15:0] s;
    longint dut_i1;
    int ones_dut, ones_mod;

    // Reset values
    repeat (2) @(negedge clock);
    check("reset a pwm", if_a.pwm, 0);
    check("reset b overload", if_b.overload, 0);
    check("reset b overload_cnt", if_b.overload_cnt, 0);
    check("reset c busy", if_c.busy, 0);
    check("reset a lfsr", u_a.lfsr_q, 16'hACE1);

    // Pin model LFSR to the reference polynomial sequence
    s = 16'hACE1;
    for (int i = 0; i < 4; i++) begin
      s = lfsr_adv(s);
      check($sformatf("lfsr ref %0d", i), s, lf_exp[i]);
    end

    reset = 1'b0;
    @(negedge clock); en = 1'b1;
    @(negedge clock);
    check("idle->run busy", if_a.busy, 1);

    // ORDER=1, vin=0: alternating
    vin = '0;
    for (int i = 0; i < 8; i++) begin
      step_n(1);
      check($sformatf("t1 a pwm %0d", i), if_a.pwm, t1_exp[i]);
      check($sformatf("t1 a overload %0d", i), if_a.overload, 0);
    end

    // ORDER=1, vin=FS/2: 1,0,1,1 and i1 sequence
    vin = 20'sh04000;
    restart();
    for (int i = 0; i < 8; i++) begin
      step_n(1);
      dut_i1 = u_a.g_stage[0].u_int.acc_q;
      check($sformatf("t2 a pwm %0d", i), if_a.pwm, t2_exp[i]);
      check($sformatf("t2 a i1 %0d", i), dut_i1, t2_i1[i]);
      check($sformatf("t2 model i1 %0d", i), m_i1[0], t2_i1[i]);
    end

    // ORDER=2, vin=FS/4: 62.5% ones, no overload
    vin = 20'sh02000;
    restart();
    ones_dut = 0; ones_mod = 0;
    for (int i = 0; i < 1024; i++) begin
      step_n(1);
      ones_dut += int'(if_b.pwm);
      ones_mod += int'(m_pwm[1]);
    end
    check("t3 model ones in 636..644", (ones_mod >= 636 && ones_mod <= 644), 1);
    check("t3 b ones", ones_dut, ones_mod);
    check("t3 b overload_cnt", if_b.overload_cnt, 0);

    // Near full-scale input: clamps from step 2, RECOVER after step 9, 16 flush steps
    vin = 20'sh7FFFF;
    restart();
    step_n(8);
    check("t4 b overload after 8", if_b.overload, 0);
    check("t4 a overload after 8", if_a.overload, 0);
    step_n(1);
    check("t4 b overload after 9", if_b.overload, 1);
    check("t4 a overload after 9", if_a.overload, 1);
    check("t4 b overload_cnt", if_b.overload_cnt, 1);
    check("t4 b busy in recover", if_b.busy, 1);
    step_n(15);
    check("t4 b still recover", if_b.overload, 1);
    step_n(1);
    check("t4 b back to run", if_b.overload, 0);
    check("t4 b busy after recover", if_b.busy, 1);
    check("t4 b overload_cnt after", if_b.overload_cnt, 1);

    // Re-overload, then drop en mid-RECOVER
    step_n(12);
    check("t5 b recover again", if_b.overload, 1);
    check("t5 b overload_cnt 2", if_b.overload_cnt, 2);
    @(negedge clock); en = 1'b0;
    @(negedge clock);
    check("t5 b idle pwm", if_b.pwm, 0);
    check("t5 b idle overload", if_b.overload, 0);
    check("t5 b idle busy", if_b.busy, 0);
    check("t5 b idle overload_cnt", if_b.overload_cnt, 2);
    en = 1'b1;
    @(negedge clock);
    check("t5 b run busy", if_b.busy, 1);
    check("t5 b run overload", if_b.overload, 0);

    // 3 steps, ce low for 10 clocks, 5 more steps: sat count reaches 7
    step_n(3);
    repeat (10) @(negedge clock);
    step_n(5);
    check("t5 b no recover yet", if_b.overload, 0);
    // en falls on the step that would enter RECOVER: IDLE wins, no count
    @(negedge clock); ce = 1'b1; en = 1'b0;
    @(negedge clock); ce = 1'b0;
    check("t5 b en-wins busy", if_b.busy, 0);
    check("t5 b en-wins overload", if_b.overload, 0);
    check("t5 b en-wins overload_cnt", if_b.overload_cnt, 2);
    check("t5 a en-wins overload_cnt", if_a.overload_cnt, 2);

    // ORDER=2 with 8-bit dither, vin=0
    vin = '0;
    restart();
    ones_dut = 0; ones_mod = 0;
    for (int i = 0; i < 1024; i++) begin
      step_n(1);
      ones_dut += int'(if_c.pwm);
      ones_mod += int'(m_pwm[2]);
    end
    check("t6 model ones in 496..528", (ones_mod >= 496 && ones_mod <= 528), 1);
    check("t6 c ones", ones_dut, ones_mod);

    // Asynchronous reset while in RECOVER
    vin = 20'sh7FFFF;
    restart();
    step_n(9);
    check("t7 b in recover", if_b.overload, 1);
    check("t7 b overload_cnt 3", if_b.overload_cnt, 3);
    #2 reset = 1'b1;
    #1;
    check("t7 b async overload", if_b.overload, 0);
    check("t7 b async overload_cnt", if_b.overload_cnt, 0);
    check("t7 b async busy", if_b.busy, 0);
    check("t7 a async pwm", if_a.pwm, 0);
    @(posedge clock);
    @(negedge clock); reset = 1'b0;
    repeat (4) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
